// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store read-modify-write controller.
//   lsu_size_e   : access size encoding carried on req_size (2'b11 is illegal)
//   lsu_state_e  : controller FSM states, also exported on the debug port
//   BYTE_W/HALF_W/WORD_W : lane widths
//   is_misaligned: alignment rule used when LSU_ALIGN_CHECK_EN is defined
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } lsu_size_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LD     = 3'd1,
    S_ST_WR  = 3'd2,
    S_RMW_RD = 3'd3,
    S_RMW_WR = 3'd4
  } lsu_state_e;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned HALF_W = 16;
  localparam int unsigned WORD_W = 32;

  // Half needs addr[0]=0, word needs addr[1:0]=0, size 2'b11 is never legal.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = off[0];
      SZ_W:    bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_rmw_ctrl_if.sv
// Core-side request/response handshake plus memory-side bus of lsu_rmw_ctrl.
//   req_*  : core -> controller request (valid/ready)
//   rsp_*  : controller -> core one-cycle response pulse
//   mem_*  : controller <-> single-port word memory (combinational read)
// Handshake: a request transfers on a rising edge where req_valid && req_ready
// are both high; the core may change the request fields after that edge.
// rsp_valid is a single-cycle pulse with no back-pressure.
// Modports: slave = controller view, master = core + memory model view.
interface lsu_rmw_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;

  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_we;
  logic [31:0]       mem_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wdata, mem_we
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational lane steering for lsu_rmw_ctrl.
//   rd_word_i, off_i, size_i, unsigned_i -> ld_data_o : extracted, extended load
//   old_word_i, wdata_i, off_i, size_i   -> st_word_o : word with lane replaced
// Any size other than byte/half is treated as a full word.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [WORD_W-1:0] rd_word_i,
  input  logic [1:0]        off_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  input  logic [WORD_W-1:0] old_word_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] ld_data_o,
  output logic [WORD_W-1:0] st_word_o
);

  logic [BYTE_W-1:0] ld_byte;
  logic [HALF_W-1:0] ld_half;

  always_comb begin
    case (off_i)
      2'd0:    ld_byte = rd_word_i[7:0];
      2'd1:    ld_byte = rd_word_i[15:8];
      2'd2:    ld_byte = rd_word_i[23:16];
      default: ld_byte = rd_word_i[31:24];
    endcase
    ld_half = off_i[1] ? rd_word_i[31:16] : rd_word_i[15:0];

    ld_data_o = rd_word_i;
    if (size_i == SZ_B) begin
      ld_data_o = {{(WORD_W-BYTE_W){~unsigned_i & ld_byte[BYTE_W-1]}}, ld_byte};
    end else if (size_i == SZ_H) begin
      ld_data_o = {{(WORD_W-HALF_W){~unsigned_i & ld_half[HALF_W-1]}}, ld_half};
    end
  end

  always_comb begin
    st_word_o = old_word_i;
    case (size_i)
      SZ_B: begin
        case (off_i)
          2'd0:    st_word_o[7:0]   = wdata_i[7:0];
          2'd1:    st_word_o[15:8]  = wdata_i[7:0];
          2'd2:    st_word_o[23:16] = wdata_i[7:0];
          default: st_word_o[31:24] = wdata_i[7:0];
        endcase
      end
      SZ_H: begin
        if (off_i[1]) st_word_o[31:16] = wdata_i[15:0];
        else          st_word_o[15:0]  = wdata_i[15:0];
      end
      default: st_word_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/lsu_rmw_ctrl.sv
// Load/store controller: turns byte/half/word loads and stores into accesses
// on a word-addressed single-port memory. Sub-word stores are done as a
// read (RMW_RD) followed by a merged full-word write (RMW_WR).
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   bus (slave)  : request/response handshake and memory bus
//   dbg_state_o  : current FSM state for observation
// Build option: LSU_ALIGN_CHECK_EN enables misalignment / illegal-size errors;
// without it low address bits are ignored and size 2'b11 acts as a word.
module lsu_rmw_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  lsu_rmw_ctrl_if.slave       bus,
  output lsu_state_e          dbg_state_o
);

  lsu_state_e        state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       merge_q, merge_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;

  logic              req_ready;
  logic              misaligned;
  logic              sub_word;
  logic              mem_we_raw;
  logic [ADDR_W-1:0] mem_addr;
  logic [ADDR_W-1:0] word_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       ld_data;
  logic [31:0]       st_word;

`ifdef LSU_ALIGN_CHECK_EN
  assign misaligned = is_misaligned(bus.req_size, bus.req_addr[1:0]);
`else
  assign misaligned = 1'b0;
`endif

  assign sub_word  = (bus.req_size == SZ_B) || (bus.req_size == SZ_H);
  assign word_addr = {addr_q[ADDR_W-1:2], 2'b00};
  assign req_ready = rst_n && (state_q == S_IDLE);

  // Load extraction reads the live memory word; store merge uses the word
  // captured during RMW_RD.
  lsu_lane_align u_align (
    .rd_word_i  (bus.mem_rdata),
    .off_i      (addr_q[1:0]),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .old_word_i (merge_q),
    .wdata_i    (wdata_q),
    .ld_data_o  (ld_data),
    .st_word_o  (st_word)
  );

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    merge_d     = merge_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_we_raw  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid && req_ready) begin
          we_d    = bus.req_we;
          size_d  = bus.req_size;
          uns_d   = bus.req_unsigned;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          if (misaligned) begin
            // Rejected without touching memory; respond next cycle.
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else if (!bus.req_we) begin
            state_d = S_LD;
          end else if (sub_word) begin
            state_d = S_RMW_RD;
          end else begin
            state_d = S_ST_WR;
          end
        end
      end
      S_LD: begin
        mem_addr    = word_addr;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = ld_data;
        state_d     = S_IDLE;
      end
      S_ST_WR: begin
        mem_addr    = word_addr;
        mem_wdata   = wdata_q;
        mem_we_raw  = 1'b1;
        rsp_valid_d = 1'b1;
        state_d     = S_IDLE;
      end
      S_RMW_RD: begin
        mem_addr = word_addr;
        merge_d  = bus.mem_rdata;
        state_d  = S_RMW_WR;
      end
      S_RMW_WR: begin
        mem_addr    = word_addr;
        mem_wdata   = st_word;
        mem_we_raw  = 1'b1;
        rsp_valid_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      merge_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      merge_q     <= merge_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  // Gated by reset so an interrupted store never reaches memory.
  assign bus.mem_we    = mem_we_raw & rst_n;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_lsu_rmw_ctrl.sv
// Self-checking bench for lsu_rmw_ctrl: word memory model, reference
// load/merge arithmetic, directed and randomized scenarios.
module tb_lsu_rmw_ctrl;
  import lsu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  lsu_state_e dbg_state;

  lsu_rmw_ctrl_if #(.ADDR_W(32)) bus ();

  lsu_rmw_ctrl #(.ADDR_W(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];
  logic        poke_en;
  logic [9:0]  poke_idx;
  logic [31:0] poke_data;
  int          wr_cnt = 0;
  logic [31:0] last_wr_addr = '0;
  logic [31:0] last_wr_data = '0;

  assign bus.mem_rdata = mem[bus.mem_addr[11:2]];

  always @(posedge clk) begin
    if (poke_en) begin
      mem[poke_idx] <= poke_data;
    end else if (bus.mem_we) begin
      mem[bus.mem_addr[11:2]] <= bus.mem_wdata;
      wr_cnt       <= wr_cnt + 1;
      last_wr_addr <= bus.mem_addr;
      last_wr_data <= bus.mem_wdata;
    end
  end

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];
  int          lat_q[$];

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [31:0] a,
                                           input logic [1:0] sz, input logic uns);
    int unsigned sh;
    logic [31:0] v;
    if (sz == 2'd0) begin
      sh = (a % 4) * 8;
      v = (w >> sh) & 32'hFF;
      if (!uns && v >= 32'd128) v = v - 32'd256;
    end else if (sz == 2'd1) begin
      sh = ((a % 4) / 2) * 16;
      v = (w >> sh) & 32'hFFFF;
      if (!uns && v >= 32'd32768) v = v - 32'd65536;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] ref_merge(input logic [31:0] old, input logic [31:0] a,
                                            input logic [1:0] sz, input logic [31:0] wd);
    int unsigned sh;
    logic [31:0] m;
    if (sz == 2'd0) begin
      sh = (a % 4) * 8;
      m = 32'hFF << sh;
      return (old & ~m) | ((wd & 32'hFF) << sh);
    end else if (sz == 2'd1) begin
      sh = ((a % 4) / 2) * 16;
      m = 32'hFFFF << sh;
      return (old & ~m) | ((wd & 32'hFFFF) << sh);
    end
    return wd;
  endfunction

  function automatic int ref_lat(input logic we, input logic [1:0] sz);
    if (we && (sz == 2'd0 || sz == 2'd1)) return 3;
    return 2;
  endfunction

  function automatic logic [31:0] rand_addr(input logic [31:0] base, input logic [1:0] sz);
    logic [31:0] off;
    off = 32'($urandom_range(0, 3));
    if (sz == 2'd1) off = off & 32'h2;
    if (sz == 2'd2) off = 32'h0;
    return base + 32'($urandom_range(0, 15)) * 4 + off;
  endfunction

  // ---------------- driver tasks ----------------
  // All tasks start and end 1 time unit after a rising edge.
  task automatic poke(input logic [31:0] addr, input logic [31:0] data);
    poke_en   = 1'b1;
    poke_idx  = addr[11:2];
    poke_data = data;
    ref_mem[addr[11:2]] = data;
    @(posedge clk); #1;
    poke_en = 1'b0;
  endtask

  task automatic set_req(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wd;
  endtask

  task automatic scramble_req();
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'($urandom_range(0, 1));
    bus.req_size     = 2'($urandom_range(0, 3));
    bus.req_unsigned = 1'($urandom_range(0, 1));
    bus.req_addr     = $urandom();
    bus.req_wdata    = $urandom();
  endtask

  task automatic drive_req(input logic we, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wd,
                           output int wait_cyc, output int lat, output logic [31:0] rdata,
                           output logic err, output int wr_seen);
    int wr0;
    set_req(we, sz, uns, addr, wd);
    wait_cyc = 0;
    @(negedge clk);
    while (!bus.req_ready && wait_cyc < 20) begin
      @(negedge clk);
      wait_cyc++;
    end
    wr0 = wr_cnt;
    @(posedge clk); #1;
    scramble_req();
    lat = -1;
    rdata = 'x;
    err = 1'bx;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) begin
        lat = i;
        rdata = bus.rsp_rdata;
        err = bus.rsp_err;
        break;
      end
    end
    wr_seen = wr_cnt - wr0;
    @(posedge clk); #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int wc, lat, ws;
    logic [31:0] rd;
    logic err;
    set_req(1'b0, 2'd2, 1'b0, 32'h8000, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.mem_we !== 1'b0) begin
        n_errors++;
        $display("FAIL reset_hold: ready=%b rsp_valid=%b mem_we=%b required 0/0/0",
                 bus.req_ready, bus.rsp_valid, bus.mem_we);
      end
      n_checks++;
      if (bus.rsp_rdata !== 32'h0 || bus.rsp_err !== 1'b0 || bus.mem_addr !== 32'h0 ||
          bus.mem_wdata !== 32'h0 || dbg_state !== S_IDLE) begin
        n_errors++;
        $display("FAIL reset_values: rdata=%h err=%b maddr=%h mwdata=%h state=%0d required zeros/IDLE",
                 bus.rsp_rdata, bus.rsp_err, bus.mem_addr, bus.mem_wdata, dbg_state);
      end
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    drive_req(1'b0, 2'd2, 1'b0, 32'h8000, 32'h0, wc, lat, rd, err, ws);
    n_checks++;
    if (wc !== 0) begin
      n_errors++;
      $display("FAIL reset_first_accept: waited %0d cycles required 0", wc);
    end
    n_checks++;
    if (lat !== 2 || rd !== 32'h80FF7F01 || err !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_first_load: lat=%0d data=%h err=%b required 2/80ff7f01/0", lat, rd, err);
    end
  endtask

  task automatic test_loads();
    logic [31:0] t_addr [7];
    logic [1:0]  t_sz   [7];
    logic        t_uns  [7];
    logic [31:0] t_exp  [7];
    int wc, lat, ws;
    logic [31:0] rd, a, exp_v;
    logic err;
    logic [1:0] sz;
    logic uns;
    t_addr = '{32'h8003, 32'h8003, 32'h8002, 32'h8000, 32'h8002, 32'h8000, 32'h8001};
    t_sz   = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd1, 2'd1, 2'd0};
    t_uns  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    t_exp  = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h80FF7F01,
               32'h000080FF, 32'h00007F01, 32'h0000007F};
    for (int i = 0; i < 7; i++) begin
      drive_req(1'b0, t_sz[i], t_uns[i], t_addr[i], $urandom(), wc, lat, rd, err, ws);
      n_checks++;
      if (rd !== t_exp[i] || lat !== 2 || err !== 1'b0 || ws !== 0) begin
        n_errors++;
        $display("FAIL load_directed[%0d]: data=%h lat=%0d err=%b writes=%0d required %h/2/0/0",
                 i, rd, lat, err, ws, t_exp[i]);
      end
    end
    for (int i = 0; i < 16; i++) poke(32'h400 + 32'(i) * 4, $urandom());
    for (int i = 0; i < 24; i++) begin
      sz = 2'($urandom_range(0, 2));
      uns = 1'($urandom_range(0, 1));
      a = rand_addr(32'h400, sz);
      exp_v = ref_load(ref_mem[a[11:2]], a, sz, uns);
      drive_req(1'b0, sz, uns, a, $urandom(), wc, lat, rd, err, ws);
      n_checks++;
      if (rd !== exp_v || lat !== 2 || err !== 1'b0) begin
        n_errors++;
        $display("FAIL load_random: addr=%h size=%0d uns=%b data=%h lat=%0d required %h/2",
                 a, sz, uns, rd, lat, exp_v);
      end
    end
  endtask

  task automatic test_subword_store();
    int wc, lat, ws;
    logic [31:0] rd;
    logic err;
    poke(32'h100, 32'h11223344);
    drive_req(1'b1, 2'd0, 1'b0, 32'h101, 32'h555555AB, wc, lat, rd, err, ws);
    n_checks++;
    if (lat !== 3 || ws !== 1 || last_wr_addr !== 32'h100 || last_wr_data !== 32'h1122AB44 ||
        rd !== 32'h0 || err !== 1'b0) begin
      n_errors++;
      $display("FAIL sb_merge: lat=%0d writes=%0d waddr=%h wdata=%h rdata=%h required 3/1/100/1122ab44/0",
               lat, ws, last_wr_addr, last_wr_data, rd);
    end
    drive_req(1'b1, 2'd1, 1'b0, 32'h102, 32'h1234BEEF, wc, lat, rd, err, ws);
    n_checks++;
    if (lat !== 3 || ws !== 1 || last_wr_data !== 32'hBEEFAB44) begin
      n_errors++;
      $display("FAIL sh_merge: lat=%0d writes=%0d wdata=%h required 3/1/beefab44",
               lat, ws, last_wr_data);
    end
  endtask

  task automatic test_random_stores();
    int wc, lat, ws;
    logic [31:0] rd, a, wd, exp_w;
    logic err;
    logic [1:0] sz;
    for (int i = 0; i < 24; i++) begin
      sz = 2'($urandom_range(0, 2));
      a = rand_addr(32'h400, sz);
      wd = $urandom();
      exp_w = ref_merge(ref_mem[a[11:2]], a, sz, wd);
      ref_mem[a[11:2]] = exp_w;
      drive_req(1'b1, sz, 1'($urandom_range(0, 1)), a, wd, wc, lat, rd, err, ws);
      n_checks++;
      if (lat !== ref_lat(1'b1, sz) || ws !== 1 || last_wr_addr !== {a[31:2], 2'b00} ||
          last_wr_data !== exp_w || rd !== 32'h0 || err !== 1'b0) begin
        n_errors++;
        $display("FAIL store_random: addr=%h size=%0d lat=%0d writes=%0d waddr=%h wdata=%h required %0d/1/%h/%h",
                 a, sz, lat, ws, last_wr_addr, last_wr_data, ref_lat(1'b1, sz), {a[31:2], 2'b00}, exp_w);
      end
    end
  endtask

  task automatic test_misaligned();
    int wc, lat, ws;
    logic [31:0] rd;
    logic err;
    poke(32'h200, 32'hA1B2C3D4);
`ifdef LSU_ALIGN_CHECK_EN
    logic [31:0] m_addr [4];
    logic [1:0]  m_sz   [4];
    logic        m_we   [4];
    m_addr = '{32'h201, 32'h202, 32'h200, 32'h201};
    m_sz   = '{2'd1, 2'd2, 2'd3, 2'd1};
    m_we   = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      drive_req(m_we[i], m_sz[i], 1'b0, m_addr[i], 32'hFFFFFFFF, wc, lat, rd, err, ws);
      n_checks++;
      if (lat !== 1 || err !== 1'b1 || rd !== 32'h0 || ws !== 0) begin
        n_errors++;
        $display("FAIL misaligned[%0d]: lat=%0d err=%b rdata=%h writes=%0d required 1/1/0/0",
                 i, lat, err, rd, ws);
      end
    end
    drive_req(1'b0, 2'd2, 1'b0, 32'h200, 32'h0, wc, lat, rd, err, ws);
    n_checks++;
    if (rd !== ref_mem[32'h200 >> 2]) begin
      n_errors++;
      $display("FAIL misaligned_mem_intact: data=%h required %h", rd, ref_mem[32'h200 >> 2]);
    end
`else
    drive_req(1'b0, 2'd2, 1'b0, 32'h202, 32'h0, wc, lat, rd, err, ws);
    n_checks++;
    if (rd !== 32'hA1B2C3D4 || lat !== 2 || err !== 1'b0) begin
      n_errors++;
      $display("FAIL lw_unaligned_nocheck: data=%h lat=%0d err=%b required a1b2c3d4/2/0", rd, lat, err);
    end
    drive_req(1'b0, 2'd3, 1'b0, 32'h200, 32'h0, wc, lat, rd, err, ws);
    n_checks++;
    if (rd !== 32'hA1B2C3D4 || lat !== 2 || err !== 1'b0) begin
      n_errors++;
      $display("FAIL size11_as_word: data=%h lat=%0d err=%b required a1b2c3d4/2/0", rd, lat, err);
    end
    drive_req(1'b0, 2'd1, 1'b0, 32'h201, 32'h0, wc, lat, rd, err, ws);
    n_checks++;
    if (rd !== 32'hFFFFC3D4 || lat !== 2 || err !== 1'b0) begin
      n_errors++;
      $display("FAIL lh_odd_nocheck: data=%h lat=%0d err=%b required ffffc3d4/2/0", rd, lat, err);
    end
`endif
  endtask

  task automatic test_reset_rmw();
    int wr0, wc, lat, ws;
    logic [31:0] rd;
    logic err;
    poke(32'h300, 32'hCAFEF00D);
    set_req(1'b1, 2'd0, 1'b0, 32'h302, 32'h00000077);
    @(negedge clk);
    @(posedge clk); #1;
    scramble_req();
    @(posedge clk); #1;
    wr0 = wr_cnt;
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (dbg_state !== S_RMW_WR || bus.mem_we !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_in_rmw_wr: state=%0d mem_we=%b required RMW_WR/0", dbg_state, bus.mem_we);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.rsp_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL reset_drop_rsp: rsp_valid=%b required 0", bus.rsp_valid);
      end
    end
    @(posedge clk); #1;
    n_checks++;
    if (wr_cnt !== wr0) begin
      n_errors++;
      $display("FAIL reset_no_write: writes=%0d required %0d", wr_cnt, wr0);
    end
    drive_req(1'b0, 2'd2, 1'b0, 32'h300, 32'h0, wc, lat, rd, err, ws);
    n_checks++;
    if (rd !== 32'hCAFEF00D) begin
      n_errors++;
      $display("FAIL reset_mem_intact: data=%h required cafef00d", rd);
    end
  endtask

  task automatic test_back_to_back();
    localparam int N = 14;
    logic        s_we   [N];
    logic [1:0]  s_sz   [N];
    logic        s_uns  [N];
    logic [31:0] s_addr [N];
    logic [31:0] s_wd   [N];
    logic [31:0] rd, exp_v;
    int lat, exp_lat, guard, wc, ws;
    logic err;
    for (int i = 0; i < 4; i++) poke(32'h500 + 32'(i) * 4, $urandom());
    s_we[0] = 1'b1; s_sz[0] = 2'd0; s_uns[0] = 1'b0; s_addr[0] = 32'h501; s_wd[0] = 32'h000000AB;
    s_we[1] = 1'b0; s_sz[1] = 2'd2; s_uns[1] = 1'b0; s_addr[1] = 32'h500; s_wd[1] = 32'h0;
    s_we[2] = 1'b1; s_sz[2] = 2'd2; s_uns[2] = 1'b0; s_addr[2] = 32'h504; s_wd[2] = 32'h13579BDF;
    for (int i = 3; i < N; i++) begin
      s_we[i]   = 1'($urandom_range(0, 1));
      s_sz[i]   = 2'($urandom_range(0, 2));
      s_uns[i]  = 1'($urandom_range(0, 1));
      s_addr[i] = 32'h500 + 32'($urandom_range(0, 3)) * 4 + 32'($urandom_range(0, 3));
      if (s_sz[i] == 2'd1) s_addr[i][0] = 1'b0;
      if (s_sz[i] == 2'd2) s_addr[i][1:0] = 2'b00;
      s_wd[i]   = $urandom();
    end
    for (int i = 0; i < N; i++) begin
      if (s_we[i]) begin
        ref_mem[s_addr[i][11:2]] = ref_merge(ref_mem[s_addr[i][11:2]], s_addr[i], s_sz[i], s_wd[i]);
        exp_q.push_back(32'h0);
      end else begin
        exp_q.push_back(ref_load(ref_mem[s_addr[i][11:2]], s_addr[i], s_sz[i], s_uns[i]));
      end
      lat_q.push_back(ref_lat(s_we[i], s_sz[i]));
    end
    set_req(s_we[0], s_sz[0], s_uns[0], s_addr[0], s_wd[0]);
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      if (k > 0) begin
        n_checks++;
        if (bus.req_ready !== 1'b1) begin
          n_errors++;
          $display("FAIL b2b_ready[%0d]: ready=%b in response cycle required 1", k, bus.req_ready);
        end
      end
      guard = 0;
      while (!bus.req_ready && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      @(posedge clk); #1;
      if (k < N - 1) set_req(s_we[k+1], s_sz[k+1], s_uns[k+1], s_addr[k+1], s_wd[k+1]);
      else scramble_req();
      lat = -1;
      rd = 'x;
      err = 1'bx;
      for (int i = 1; i <= 8; i++) begin
        @(negedge clk);
        if (bus.rsp_valid === 1'b1) begin
          lat = i;
          rd = bus.rsp_rdata;
          err = bus.rsp_err;
          break;
        end
      end
      exp_v = exp_q.pop_front();
      exp_lat = lat_q.pop_front();
      n_checks++;
      if (lat !== exp_lat || rd !== exp_v || err !== 1'b0) begin
        n_errors++;
        $display("FAIL b2b_rsp[%0d]: lat=%0d data=%h err=%b required %0d/%h/0", k, lat, rd, err, exp_lat, exp_v);
      end
    end
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      drive_req(1'b0, 2'd2, 1'b0, 32'h500 + 32'(i) * 4, 32'h0, wc, lat, rd, err, ws);
      n_checks++;
      if (rd !== ref_mem[(32'h500 >> 2) + i]) begin
        n_errors++;
        $display("FAIL b2b_readback[%0d]: data=%h required %h", i, rd, ref_mem[(32'h500 >> 2) + i]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    poke_en = 1'b0;
    poke_idx = '0;
    poke_data = '0;
    scramble_req();
    @(posedge clk); #1;
    poke(32'h8000, 32'h80FF7F01);
    test_reset();
    test_loads();
    test_subword_store();
    test_random_stores();
    test_misaligned();
    test_reset_rmw();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
